user_pulse_sequencer: RTL and testbench

Sequences the user pulse generator through a programmable list of pulse-train descriptors, repeated a programmable number of loops. Sits in the user domain between the register interface (descriptor writes, start/abort, status) and the pulser's configuration/start/stop inputs. Holds pulser configuration stable for the whole run of each descriptor. Uses the pulser's 3-bit state output to detect completion.

---
 rtl/user_pulse_seq_pkg.sv | 28 ++
 rtl/user_pulse_desc_table.sv | 31 +++
 rtl/user_pulse_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_user_pulse_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pulse_seq_pkg.sv
// Shared types and constants for the user pulse sequencer.
// Optional watchdog is enabled with `define USER_PULSE_SEQ_TIMEOUT_EN.
package user_pulse_seq_pkg;

  // 120-bit descriptor, MSB first; the top 16 bits are reserved.
  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  f1_cnt;
    logic [7:0]  f2_cnt;
    logic [7:0]  stop_cnt;
    logic [15:0] f1_end;
    logic [15:0] f1_switch;
    logic [15:0] f2_end;
    logic [15:0] f2_switch;
    logic [15:0] gap;
  } pulse_desc_t;

  localparam logic [2:0] PULSER_IDLE = 3'd0;
  localparam logic [2:0] PULSER_DONE = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StGap
  } seq_state_e;

endpackage

// File: rtl/user_pulse_desc_table.sv
// Descriptor storage: flop array with one write port and one combinational read port.
module user_pulse_desc_table
  import user_pulse_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  pulse_desc_t      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output pulse_desc_t      rdata_o
);

  pulse_desc_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/user_pulse_sequencer.sv
// Walks the pulser through the descriptor table for loops_i+1 passes.
// `define USER_PULSE_SEQ_TIMEOUT_EN adds a per-descriptor WAIT watchdog.
module user_pulse_sequencer
  import user_pulse_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000,
  localparam int unsigned IDX_W         = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_addr_i,
  input  logic [119:0]     cfg_wdata_i,
  input  logic [IDX_W:0]   num_entries_i,
  input  logic [7:0]       loops_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [2:0]       pulser_state_i,
  output logic             pulser_start_o,
  output logic             pulser_stop_o,
  output logic [7:0]       f1_cnt_o,
  output logic [7:0]       f2_cnt_o,
  output logic [7:0]       stop_cnt_o,
  output logic [15:0]      f1_end_o,
  output logic [15:0]      f1_switch_o,
  output logic [15:0]      f2_end_o,
  output logic [15:0]      f2_switch_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             cfg_err_o,
  output logic [IDX_W-1:0] cur_idx_o,
  output logic [7:0]       loops_left_o
);

  localparam logic [IDX_W:0] DepthW = (IDX_W+1)'(DEPTH);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [7:0]       loops_q, loops_d;
  logic [15:0]      gap_q, gap_d;
  pulse_desc_t      cfg_q, cfg_d, rd_desc;
  logic             done_q, done_d, abort_q, abort_d, err_q, err_d;
  logic             load, advance, busy, timeout;
  logic [IDX_W:0]   n_clamp;

  assign busy    = (state_q != StIdle);
  assign n_clamp = (num_entries_i > DepthW) ? DepthW : num_entries_i;

  user_pulse_desc_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (cfg_we_i && !busy),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_wdata_i),
    .raddr_i (idx_d),
    .rdata_o (rd_desc)
  );

`ifdef USER_PULSE_SEQ_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == StIssue) begin
      wdog_d = '0;
    end else if (state_q == StWait) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle so the abort lands exactly that many cycles in.
  assign timeout = (state_q == StWait) && (wdog_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loops_d = loops_q;
    gap_d   = gap_q;
    load    = 1'b0;
    advance = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    err_d   = cfg_we_i && busy;

    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          if (n_clamp != '0) begin
            state_d = StIssue;
            idx_d   = '0;
            last_d  = IDX_W'(n_clamp - 1'b1);
            loops_d = loops_i;
            load    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (pulser_state_i == PULSER_DONE) begin
          if (cfg_q.gap != 16'd0) begin
            state_d = StGap;
            gap_d   = cfg_q.gap;
          end else begin
            advance = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_q == 16'd1) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (idx_q != last_q) begin
        idx_d   = idx_q + 1'b1;
        state_d = StIssue;
        load    = 1'b1;
      end else if (loops_q != 8'd0) begin
        loops_d = loops_q - 8'd1;
        idx_d   = '0;
        state_d = StIssue;
        load    = 1'b1;
      end else begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end

    // Abort and watchdog override every other event in the same cycle.
    if (busy && (abort_i || timeout)) begin
      state_d = StIdle;
      idx_d   = idx_q;
      loops_d = loops_q;
      load    = 1'b0;
      done_d  = 1'b0;
      abort_d = 1'b1;
    end
  end

  assign cfg_d = load ? rd_desc : cfg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      loops_q <= '0;
      gap_q   <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loops_q <= loops_d;
      gap_q   <= gap_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  logic unused_rsvd;
  assign unused_rsvd = ^cfg_q.rsvd;

  assign pulser_start_o = (state_q == StIssue);
  assign pulser_stop_o  = abort_q;
  assign aborted_o      = abort_q;
  assign done_o         = done_q;
  assign cfg_err_o      = err_q;
  assign busy_o         = busy;
  assign cur_idx_o      = idx_q;
  assign loops_left_o   = loops_q;
  assign f1_cnt_o       = cfg_q.f1_cnt;
  assign f2_cnt_o       = cfg_q.f2_cnt;
  assign stop_cnt_o     = cfg_q.stop_cnt;
  assign f1_end_o       = cfg_q.f1_end;
  assign f1_switch_o    = cfg_q.f1_switch;
  assign f2_end_o       = cfg_q.f2_end;
  assign f2_switch_o    = cfg_q.f2_switch;

endmodule

// File: tb/tb_user_pulse_sequencer.sv
// Directed bench for user_pulse_sequencer with a behavioural pulser model.
module tb_user_pulse_sequencer;
  import user_pulse_seq_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             cfg_we_i = 1'b0;
  logic [IDX_W-1:0] cfg_addr_i = '0;
  logic [119:0]     cfg_wdata_i = '0;
  logic [IDX_W:0]   num_entries_i = '0;
  logic [7:0]       loops_i = '0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [2:0]       pulser_state_i;
  logic             pulser_start_o, pulser_stop_o, busy_o, done_o, aborted_o, cfg_err_o;
  logic [7:0]       f1_cnt_o, f2_cnt_o, stop_cnt_o, loops_left_o;
  logic [15:0]      f1_end_o, f1_switch_o, f2_end_o, f2_switch_o;
  logic [IDX_W-1:0] cur_idx_o;

  user_pulse_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cfg_we_i       (cfg_we_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_wdata_i    (cfg_wdata_i),
    .num_entries_i  (num_entries_i),
    .loops_i        (loops_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .pulser_state_i (pulser_state_i),
    .pulser_start_o (pulser_start_o),
    .pulser_stop_o  (pulser_stop_o),
    .f1_cnt_o       (f1_cnt_o),
    .f2_cnt_o       (f2_cnt_o),
    .stop_cnt_o     (stop_cnt_o),
    .f1_end_o       (f1_end_o),
    .f1_switch_o    (f1_switch_o),
    .f2_end_o       (f2_end_o),
    .f2_switch_o    (f2_switch_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o),
    .cfg_err_o      (cfg_err_o),
    .cur_idx_o      (cur_idx_o),
    .loops_left_o   (loops_left_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Pulser model: F1 for run_len+1 cycles, one DONE cycle, then IDLE.
  int   run_len = 3;
  bit   stuck = 1'b0;
  int   pcnt;
  logic [2:0] ps;
  assign pulser_state_i = ps;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps <= PULSER_IDLE; pcnt <= 0;
    end else if (pulser_stop_o) begin
      ps <= PULSER_IDLE;
    end else if (pulser_start_o) begin
      ps <= 3'd1; pcnt <= run_len;
    end else if (ps == 3'd1) begin
      if (!stuck) begin
        if (pcnt == 0) ps <= PULSER_DONE;
        else pcnt <= pcnt - 1;
      end
    end else if (ps == PULSER_DONE) begin
      ps <= PULSER_IDLE;
    end
  end

  // Event monitor, sampled on the falling edge.
  int start_cyc_q[$], start_idx_q[$], start_f1_q[$], start_gap_q[$], start_loops_q[$];
  int done_cnt, done_cyc, abort_cnt, abort_cyc, stop_cnt, err_cnt, err_cyc, last_dn_cyc;
  always @(negedge clk_i) begin
    if (pulser_start_o) begin
      start_cyc_q.push_back(cyc);
      start_idx_q.push_back(int'(cur_idx_o));
      start_f1_q.push_back(int'(f1_cnt_o));
      start_gap_q.push_back(cyc - last_dn_cyc);
      start_loops_q.push_back(int'(loops_left_o));
    end
    if (pulser_state_i == PULSER_DONE) last_dn_cyc = cyc;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (aborted_o) begin abort_cnt++; abort_cyc = cyc; end
    if (pulser_stop_o) stop_cnt++;
    if (cfg_err_o) begin err_cnt++; err_cyc = cyc; end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    start_cyc_q.delete(); start_idx_q.delete(); start_f1_q.delete();
    start_gap_q.delete(); start_loops_q.delete();
    done_cnt = 0; done_cyc = -1; abort_cnt = 0; abort_cyc = -1;
    stop_cnt = 0; err_cnt = 0; err_cyc = -1; last_dn_cyc = -1;
  endtask

  task automatic wr_entry(input int idx, input int f1, input int gap);
    pulse_desc_t d;
    d = '0;
    d.rsvd = 16'hdead; d.f1_cnt = 8'(f1); d.f2_cnt = 8'(f1 + 16); d.stop_cnt = 8'd1;
    d.f1_end = 16'd4; d.f1_switch = 16'd2; d.f2_end = 16'd6; d.f2_switch = 16'd3;
    d.gap = 16'(gap);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = IDX_W'(idx); cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk_i);
    start_i = 1'b1; t = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (done_cnt > 0 || abort_cnt > 0) begin ok = 1; break; end
    end
    repeat (2) @(negedge clk_i);
  endtask

  typedef struct {
    int n;
    int loops;
    int gap0;
    int neff;
    int exp_starts;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, ok, neff, pidx;
    vecs[0] = '{n: 1,  loops: 0, gap0: 0, neff: 1, exp_starts: 1};
    vecs[1] = '{n: 2,  loops: 1, gap0: 5, neff: 2, exp_starts: 4};
    vecs[2] = '{n: 0,  loops: 0, gap0: 0, neff: 0, exp_starts: 0};
    vecs[3] = '{n: 11, loops: 0, gap0: 0, neff: 8, exp_starts: 8};
    vecs[4] = '{n: 3,  loops: 2, gap0: 2, neff: 3, exp_starts: 9};

    clear_mon();
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", int'(|{pulser_start_o, pulser_stop_o, busy_o, done_o, aborted_o,
        cfg_err_o, cur_idx_o, loops_left_o, f1_cnt_o, f2_cnt_o, stop_cnt_o, f1_end_o,
        f1_switch_o, f2_end_o, f2_switch_o}), 0);
    rst_ni = 1'b1;

    // Table-driven runs.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) wr_entry(i, i + 1, (i == 0) ? vecs[r].gap0 : 0);
      num_entries_i = (IDX_W+1)'(vecs[r].n);
      loops_i = 8'(vecs[r].loops);
      neff = vecs[r].neff;
      clear_mon();
      pulse_start(t);
      wait_end(3000, ok);
      chk($sformatf("v%0d_completed", r), ok, 1);
      chk($sformatf("v%0d_starts", r), start_cyc_q.size(), vecs[r].exp_starts);
      chk($sformatf("v%0d_done_cnt", r), done_cnt, 1);
      chk($sformatf("v%0d_abort_cnt", r), abort_cnt, 0);
      chk($sformatf("v%0d_busy_end", r), int'(busy_o), 0);
      if (vecs[r].exp_starts == 0) begin
        chk($sformatf("v%0d_done_lat", r), done_cyc, t + 1);
      end else begin
        chk($sformatf("v%0d_start_lat", r), start_cyc_q[0], t + 1);
        chk($sformatf("v%0d_done_lat", r), done_cyc, last_dn_cyc + 1);
        chk($sformatf("v%0d_loops_end", r), int'(loops_left_o), 0);
      end
      for (int k = 0; k < start_cyc_q.size() && k < vecs[r].exp_starts; k++) begin
        chk($sformatf("v%0d_s%0d_idx", r, k), start_idx_q[k], k % neff);
        chk($sformatf("v%0d_s%0d_f1", r, k), start_f1_q[k], (k % neff) + 1);
        chk($sformatf("v%0d_s%0d_loops", r, k), start_loops_q[k], vecs[r].loops - k / neff);
        if (k > 0) begin
          pidx = (k - 1) % neff;
          chk($sformatf("v%0d_s%0d_gap", r, k), start_gap_q[k],
              ((pidx == 0) ? vecs[r].gap0 : 0) + 1);
        end
      end
    end

    // Abort while waiting on entry 1, then restart from entry 0.
    wr_entry(0, 1, 0);
    num_entries_i = 4'd2; loops_i = 8'd0; run_len = 20;
    clear_mon();
    pulse_start(t);
    for (int i = 0; i < 200 && start_cyc_q.size() < 2; i++) @(negedge clk_i);
    chk("abort_reached_idx1", start_cyc_q.size(), 2);
    repeat (3) @(negedge clk_i);
    abort_i = 1'b1; t = cyc;
    @(negedge clk_i);
    abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("abort_cycle", abort_cyc, t + 1);
    chk("abort_pulses", abort_cnt, 1);
    chk("abort_stop_pulses", stop_cnt, 1);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", int'(busy_o), 0);
    run_len = 3;
    clear_mon();
    pulse_start(t);
    wait_end(500, ok);
    chk("restart_done", done_cnt, 1);
    chk("restart_idx0", (start_idx_q.size() > 0) ? start_idx_q[0] : -1, 0);

    // Write while busy is dropped; rerun shows entry 1 unchanged.
    clear_mon();
    pulse_start(t);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = 3'd1; cfg_wdata_i = '1; t = cyc;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    wait_end(500, ok);
    chk("cfg_err_cnt", err_cnt, 1);
    chk("cfg_err_cycle", err_cyc, t + 1);
    clear_mon();
    pulse_start(t);
    wait_end(500, ok);
    chk("cfg_err_table_kept", (start_f1_q.size() > 1) ? start_f1_q[1] : -1, 2);

    // Same-cycle start and abort in IDLE do nothing.
    clear_mon();
    @(negedge clk_i);
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("idle_sa_starts", start_cyc_q.size(), 0);
    chk("idle_sa_events", done_cnt + abort_cnt + stop_cnt, 0);
    chk("idle_sa_busy", int'(busy_o), 0);

`ifdef USER_PULSE_SEQ_TIMEOUT_EN
    // Watchdog: pulser stuck in F1.
    stuck = 1'b1; num_entries_i = 4'd1;
    clear_mon();
    pulse_start(t);
    wait_end(400, ok);
    chk("wdog_fired", abort_cnt, 1);
    chk("wdog_latency", (start_cyc_q.size() > 0) ? abort_cyc - (start_cyc_q[0] + 1) : -1, 100);
    chk("wdog_no_done", done_cnt, 0);
    stuck = 1'b0;
`endif

    // Reset mid-WAIT clears outputs without waiting for a clock edge.
    run_len = 50; num_entries_i = 4'd2;
    clear_mon();
    pulse_start(t);
    repeat (5) @(negedge clk_i);
    chk("pre_reset_busy", int'(busy_o), 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("reset_async_outputs", int'(|{pulser_start_o, pulser_stop_o, busy_o, done_o, aborted_o,
        cfg_err_o, cur_idx_o, loops_left_o, f1_cnt_o, f2_cnt_o, stop_cnt_o, f1_end_o,
        f1_switch_o, f2_end_o, f2_switch_o}), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
